// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: port owner tags, arbiter
// states and the read-tag record carried alongside each bsram read.
// Optional debug requester port is enabled with `define DMEM_DEBUG_PORT_EN.
package dmem_port_arbiter_pkg;

    localparam int DMEM_AW_DEFAULT = 12;

    // Who issued a given read; the encoding is visible on rd_owner.
    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_RCC = 2'd1,
        OWN_DBG = 2'd2
    } dmem_owner_t;

    // Ownership handoff sequence, repeated once per frame.
    typedef enum logic [1:0] {
        ST_CPU_OWN,
        ST_DRAIN_TO_COPY,
        ST_COPY_OWN,
        ST_DRAIN_TO_CPU
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        dmem_owner_t owner;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, owner: OWN_CPU};

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Shift register that delays each read's {valid, owner} tag by the bsram
// read latency, so the tag lines up with the data returning from memory.
module dmem_rd_tag_pipe
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] in_owner,
    output logic       out_valid,
    output logic [1:0] out_owner
);

    rd_tag_t stage [DEPTH];

    // Advance the tag pipe one stage per cycle; reset drops in-flight reads.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            // NOTE: this storage array is reset on purpose -- a stale valid
            // bit after reset would report a read that never happened.
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RD_TAG_IDLE;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of its predecessor, which is what makes this a shift.
            stage[0] <= '{valid: in_valid, owner: dmem_owner_t'(in_owner)};
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_valid = stage[DEPTH-1].valid;
    assign out_owner = stage[DEPTH-1].owner;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Owns the bsram read/write ports and time-slices them between the CPU and
// the copy engines (RCC reads, BC writes), draining in-flight reads before
// each ownership change. Every returning read carries an owner tag.
// `define DMEM_DEBUG_PORT_EN adds a debug requester that steals single
// cycles from the CPU.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_ADDR_WIDTH = DMEM_AW_DEFAULT,
    parameter int RD_LATENCY      = 1,
    parameter int DBG_MAX_WAIT    = 15
) (
    input  logic                       system_clk,
    input  logic                       reset,
    input  logic                       copy_req,
    output logic                       copy_grant,
    output logic                       cpu_stall,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_rd_addr,
    input  logic                       cpu_we,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_wr_addr,
    input  logic [15:0]                cpu_wr_data,
    input  logic [DATA_ADDR_WIDTH-1:0] rcc_rd_addr,
    input  logic                       bc_we,
    input  logic [DATA_ADDR_WIDTH-1:0] bc_wr_addr,
    input  logic [15:0]                bc_wr_data,
`ifdef DMEM_DEBUG_PORT_EN
    input  logic                       dbg_req,
    input  logic                       dbg_we,
    input  logic [DATA_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [15:0]                dbg_wr_data,
    output logic                       dbg_ack,
`endif
    output logic [DATA_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                       mem_we,
    output logic [DATA_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [15:0]                mem_wr_data,
    input  logic [15:0]                mem_rd_data,
    output logic [15:0]                rd_data,
    output logic [1:0]                 rd_owner,
    output logic                       rd_valid
);

    localparam logic [1:0] DRAIN_LAST = 2'(RD_LATENCY - 1);

    // Reject parameter values the drain counter and wait counter cannot handle.
    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_rd_latency
        $error("dmem_port_arbiter: RD_LATENCY must be 1 or 2");
    end
    if (DBG_MAX_WAIT < 1) begin : g_bad_dbg_wait
        $error("dmem_port_arbiter: DBG_MAX_WAIT must be at least 1");
    end

    arb_state_t                 state, state_nxt;
    logic [1:0]                 drain_cnt, drain_cnt_nxt;
    logic                       drain_done;
    logic [DATA_ADDR_WIDTH-1:0] last_rd_addr;
    logic                       issue_valid;
    dmem_owner_t                issue_owner;
    logic                       dbg_serve;

    assign drain_done = (drain_cnt == DRAIN_LAST);

`ifdef DMEM_DEBUG_PORT_EN
    localparam int DBG_CNT_W = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [DBG_CNT_W-1:0] DBG_LIMIT = DBG_CNT_W'(DBG_MAX_WAIT);

    logic [DBG_CNT_W-1:0] dbg_wait_cnt;
    logic                 cpu_idle;

    // The CPU is idle when it neither writes nor moves its read address.
    assign cpu_idle  = !cpu_we && (cpu_rd_addr == last_rd_addr);
    assign dbg_serve = !reset && dbg_req && (state == ST_CPU_OWN) &&
                       (cpu_idle || (dbg_wait_cnt >= DBG_LIMIT));
    assign dbg_ack   = dbg_serve;

    // Count how long the debug request has waited while the CPU owns the ports.
    always_ff @(posedge system_clk) begin
        if (reset || !dbg_req || dbg_serve) begin
            dbg_wait_cnt <= '0;
        end else if (state == ST_CPU_OWN && dbg_wait_cnt < DBG_LIMIT) begin
            dbg_wait_cnt <= dbg_wait_cnt + 1'b1;
        end
    end
`else
    assign dbg_serve = 1'b0;
`endif

    // State register, drain counter and the last issued read address.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            state        <= ST_CPU_OWN;
            drain_cnt    <= '0;
            last_rd_addr <= '0;
        end else begin
            state        <= state_nxt;
            drain_cnt    <= drain_cnt_nxt;
            last_rd_addr <= mem_rd_addr;
        end
    end

    // Next-state logic for the CPU -> copy -> CPU handoff with read draining.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            ST_CPU_OWN: begin
                if (copy_req) begin
                    state_nxt     = ST_DRAIN_TO_COPY;
                    drain_cnt_nxt = '0;
                end
            end
            ST_DRAIN_TO_COPY: begin
                if (!copy_req) begin
                    state_nxt     = ST_CPU_OWN;
                    drain_cnt_nxt = '0;
                end else if (drain_done) begin
                    state_nxt     = ST_COPY_OWN;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + 2'd1;
                end
            end
            ST_COPY_OWN: begin
                if (!copy_req) begin
                    state_nxt     = ST_DRAIN_TO_CPU;
                    drain_cnt_nxt = '0;
                end
            end
            ST_DRAIN_TO_CPU: begin
                if (drain_done) begin
                    state_nxt     = ST_CPU_OWN;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + 2'd1;
                end
            end
            default: begin
                state_nxt     = ST_CPU_OWN;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    // Port mux: the current owner drives bsram; drain states hold the read
    // address and block writes so nothing new enters the read pipe.
    always_comb begin
        copy_grant  = (state == ST_COPY_OWN);
        cpu_stall   = (state != ST_CPU_OWN) || dbg_serve;
        mem_rd_addr = last_rd_addr;
        mem_we      = 1'b0;
        mem_wr_addr = cpu_wr_addr;
        mem_wr_data = cpu_wr_data;
        issue_valid = 1'b0;
        issue_owner = OWN_CPU;
        case (state)
            ST_CPU_OWN: begin
                issue_valid = 1'b1;
                if (dbg_serve) begin
`ifdef DMEM_DEBUG_PORT_EN
                    mem_rd_addr = dbg_addr;
                    mem_we      = dbg_we;
                    mem_wr_addr = dbg_addr;
                    mem_wr_data = dbg_wr_data;
`endif
                    issue_owner = OWN_DBG;
                end else begin
                    mem_rd_addr = cpu_rd_addr;
                    mem_we      = cpu_we;
                end
            end
            ST_COPY_OWN: begin
                mem_rd_addr = rcc_rd_addr;
                mem_we      = bc_we;
                mem_wr_addr = bc_wr_addr;
                mem_wr_data = bc_wr_data;
                issue_valid = 1'b1;
                issue_owner = OWN_RCC;
            end
            default: begin
            end
        endcase
        if (reset) begin
            mem_rd_addr = '0;
            mem_we      = 1'b0;
            mem_wr_addr = '0;
            mem_wr_data = '0;
            issue_valid = 1'b0;
        end
    end

    dmem_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .system_clk (system_clk),
        .reset      (reset),
        .in_valid   (issue_valid),
        .in_owner   (issue_owner),
        .out_valid  (rd_valid),
        .out_owner  (rd_owner)
    );

    assign rd_data = mem_rd_data;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 1-cycle bsram model.
module tb_dmem_port_arbiter;

    localparam int AW = 12;

    logic          system_clk = 1'b0;
    logic          reset = 1'b1;
    logic          copy_req = 1'b0;
    logic          copy_grant, cpu_stall;
    logic [AW-1:0] cpu_rd_addr = '0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_wr_addr = 12'h020;
    logic [15:0]   cpu_wr_data = 16'h1234;
    logic [AW-1:0] rcc_rd_addr = 12'h100;
    logic          bc_we = 1'b0;
    logic [AW-1:0] bc_wr_addr = 12'h0F0;
    logic [15:0]   bc_wr_data = 16'hBEEF;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic          mem_we;
    logic [15:0]   mem_wr_data, mem_rd_data, rd_data;
    logic [1:0]    rd_owner;
    logic          rd_valid;
`ifdef DMEM_DEBUG_PORT_EN
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = 12'h033;
    logic [15:0]   dbg_wr_data = 16'h0000;
    logic          dbg_ack;
`endif

    int total = 0;
    int bad   = 0;

    always #5 system_clk = ~system_clk;

    dmem_port_arbiter #(
        .DATA_ADDR_WIDTH (AW),
        .RD_LATENCY      (1),
        .DBG_MAX_WAIT    (15)
    ) dut (
        .system_clk  (system_clk),
        .reset       (reset),
        .copy_req    (copy_req),
        .copy_grant  (copy_grant),
        .cpu_stall   (cpu_stall),
        .cpu_rd_addr (cpu_rd_addr),
        .cpu_we      (cpu_we),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .rcc_rd_addr (rcc_rd_addr),
        .bc_we       (bc_we),
        .bc_wr_addr  (bc_wr_addr),
        .bc_wr_data  (bc_wr_data),
`ifdef DMEM_DEBUG_PORT_EN
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wr_data (dbg_wr_data),
        .dbg_ack     (dbg_ack),
`endif
        .mem_rd_addr (mem_rd_addr),
        .mem_we      (mem_we),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .rd_data     (rd_data),
        .rd_owner    (rd_owner),
        .rd_valid    (rd_valid)
    );

    // bsram model: 1-cycle read latency, preloaded with addr ^ 0x5A00.
    logic [15:0] bram [4096];
    initial begin
        for (int a = 0; a < 4096; a++) bram[a] = 16'(a) ^ 16'h5A00;
    end
    always @(posedge system_clk) begin
        if (mem_we) bram[mem_wr_addr] <= mem_wr_data;
        mem_rd_data <= bram[mem_rd_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge system_clk);
        #1;
    endtask

    typedef struct {
        logic          copy_req;
        logic          cpu_we;
        logic          bc_we;
        logic [AW-1:0] cpu_rd_addr;
        logic [AW-1:0] rcc_rd_addr;
        logic          exp_grant;
        logic          exp_stall;
        logic          exp_we;
        logic          exp_valid;
        logic [1:0]    exp_owner;
        logic [AW-1:0] exp_rd_addr;
        logic [15:0]   exp_data;
    } vec_t;

    vec_t vecs [14];

    initial begin
        //          creq we bcwe cpu_rd   rcc_rd   grant stall mwe val own rd_addr  data
        vecs[0]  = '{1'b0,1'b0,1'b0,12'h010,12'h100,1'b0,1'b0,1'b0,1'b0,2'd0,12'h010,16'h0000};
        vecs[1]  = '{1'b0,1'b1,1'b0,12'h011,12'h100,1'b0,1'b0,1'b1,1'b1,2'd0,12'h011,16'h5A10};
        vecs[2]  = '{1'b1,1'b0,1'b0,12'h012,12'h100,1'b0,1'b0,1'b0,1'b1,2'd0,12'h012,16'h5A11};
        vecs[3]  = '{1'b1,1'b1,1'b0,12'h013,12'h100,1'b0,1'b1,1'b0,1'b1,2'd0,12'h012,16'h5A12};
        vecs[4]  = '{1'b1,1'b0,1'b1,12'h013,12'h100,1'b1,1'b1,1'b1,1'b0,2'd0,12'h100,16'h0000};
        vecs[5]  = '{1'b1,1'b0,1'b0,12'h013,12'h101,1'b1,1'b1,1'b0,1'b1,2'd1,12'h101,16'h5B00};
        vecs[6]  = '{1'b0,1'b0,1'b0,12'h013,12'h102,1'b1,1'b1,1'b0,1'b1,2'd1,12'h102,16'h5B01};
        vecs[7]  = '{1'b0,1'b1,1'b1,12'h014,12'h103,1'b0,1'b1,1'b0,1'b1,2'd1,12'h102,16'h5B02};
        vecs[8]  = '{1'b0,1'b0,1'b0,12'h0F0,12'h100,1'b0,1'b0,1'b0,1'b0,2'd0,12'h0F0,16'h0000};
        vecs[9]  = '{1'b0,1'b0,1'b0,12'h015,12'h100,1'b0,1'b0,1'b0,1'b1,2'd0,12'h015,16'hBEEF};
        vecs[10] = '{1'b1,1'b0,1'b0,12'h016,12'h100,1'b0,1'b0,1'b0,1'b1,2'd0,12'h016,16'h5A15};
        vecs[11] = '{1'b0,1'b0,1'b0,12'h017,12'h100,1'b0,1'b1,1'b0,1'b1,2'd0,12'h016,16'h5A16};
        vecs[12] = '{1'b0,1'b0,1'b0,12'h018,12'h100,1'b0,1'b0,1'b0,1'b0,2'd0,12'h018,16'h0000};
        vecs[13] = '{1'b0,1'b0,1'b0,12'h019,12'h100,1'b0,1'b0,1'b0,1'b1,2'd0,12'h019,16'h5A18};

        // Reset held for 5 idle cycles: everything quiet.
        step();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("reset%0d copy_grant", c), 32'(copy_grant), 32'd0);
            check($sformatf("reset%0d cpu_stall", c), 32'(cpu_stall), 32'd0);
            check($sformatf("reset%0d mem_we", c), 32'(mem_we), 32'd0);
            check($sformatf("reset%0d rd_valid", c), 32'(rd_valid), 32'd0);
            step();
        end

        // Table: CPU reads, handoff to copy, BC write, handoff back, aborted drain.
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            copy_req    = vecs[i].copy_req;
            cpu_we      = vecs[i].cpu_we;
            bc_we       = vecs[i].bc_we;
            cpu_rd_addr = vecs[i].cpu_rd_addr;
            rcc_rd_addr = vecs[i].rcc_rd_addr;
            #1;
            check($sformatf("row%0d copy_grant", i), 32'(copy_grant), 32'(vecs[i].exp_grant));
            check($sformatf("row%0d cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].exp_stall));
            check($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
            check($sformatf("row%0d mem_rd_addr", i), 32'(mem_rd_addr), 32'(vecs[i].exp_rd_addr));
            check($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("row%0d rd_owner", i), 32'(rd_owner), 32'(vecs[i].exp_owner));
                check($sformatf("row%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
            end
            if (vecs[i].exp_we) begin
                check($sformatf("row%0d mem_wr_data", i), 32'(mem_wr_data),
                      vecs[i].bc_we ? 32'h0000BEEF : 32'h00001234);
            end
            step();
        end

        // Reset asserted while the copy engines own the ports.
        copy_req = 1'b1;
        cpu_we   = 1'b0;
        bc_we    = 1'b0;
        step();
        step();
        check("copy_own before reset", 32'(copy_grant), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("post-reset copy_grant", 32'(copy_grant), 32'd0);
        check("post-reset cpu_stall", 32'(cpu_stall), 32'd0);
        check("post-reset rd_valid", 32'(rd_valid), 32'd0);
        copy_req = 1'b0;
        step();
        check("post-reset back to cpu", 32'(cpu_stall), 32'd0);

`ifdef DMEM_DEBUG_PORT_EN
        // Debug request starved by a CPU writing every cycle: served on the 16th cycle.
        begin
            int waited;
            bit acked;
            waited = 0;
            acked  = 1'b0;
            cpu_we  = 1'b1;
            dbg_req = 1'b1;
            for (int n = 0; n < 40 && !acked; n++) begin
                #1;
                if (dbg_ack) begin
                    acked  = 1'b1;
                    waited = n;
                    check("dbg stall on ack", 32'(cpu_stall), 32'd1);
                    check("dbg mem_rd_addr", 32'(mem_rd_addr), 32'h033);
                    check("dbg blocks cpu_we", 32'(mem_we), 32'd0);
                end else begin
                    step();
                end
            end
            check("dbg acked in budget", 32'(acked), 32'd1);
            check("dbg wait cycles", 32'(waited), 32'd15);
            step();
            dbg_req = 1'b0;
            cpu_we  = 1'b0;
            #1;
            check("dbg stall released", 32'(cpu_stall), 32'd0);
            check("dbg rd_valid", 32'(rd_valid), 32'd1);
            check("dbg rd_owner", 32'(rd_owner), 32'd2);
            check("dbg rd_data", 32'(rd_data), 32'h5A33);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
